// File: rtl/ds_adc.sv
// Delta-sigma ADC front end: comparator synchroniser, 1-bit feedback and boxcar decimator.
// Optional macro DS_ADC_AVG2_EN averages each window result with the previous one.
module ds_adc #(
  parameter int MSBI_G   = 7,
  parameter int DEC_LOG2 = 8
) (
  input  logic            clk_i,
  input  logic            res_n_i,
  input  logic            cmp_i,
  output logic            fb_o,
  output logic [MSBI_G:0] adc_o,
  output logic            valid_o
);

  localparam int SHIFT = DEC_LOG2 - MSBI_G - 1;
  localparam logic [DEC_LOG2:0] MAX_CODE = (DEC_LOG2 + 1)'((2 ** (MSBI_G + 1)) - 1);

  generate
    if (DEC_LOG2 < MSBI_G + 1) begin : g_bad_cfg
      $error("ds_adc: DEC_LOG2 must be >= MSBI_G+1");
    end
  endgenerate

  logic                sync_1;
  logic                sync_2;
  logic [DEC_LOG2-1:0] win_cnt;
  logic [DEC_LOG2:0]   acc;
  logic [DEC_LOG2:0]   total;
  logic [DEC_LOG2:0]   scaled;
  logic [MSBI_G:0]     result;
  logic                win_end;

  assign win_end = &win_cnt;

  // A window of all ones totals 2^DEC_LOG2, one past full scale: clamp instead of wrapping.
  always_comb begin
    total  = acc + {{DEC_LOG2{1'b0}}, sync_2};
    scaled = total >> SHIFT;
    result = (scaled > MAX_CODE) ? '1 : scaled[MSBI_G:0];
  end

  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      fb_o   <= 1'b0;
    end else begin
      sync_1 <= cmp_i;
      sync_2 <= sync_1;
      fb_o   <= sync_2;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      win_cnt <= '0;
      acc     <= '0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
      acc     <= win_end ? '0 : total;
    end
  end

`ifdef DS_ADC_AVG2_EN
  logic [MSBI_G:0] prev;

  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      prev    <= '0;
      adc_o   <= '0;
      valid_o <= 1'b0;
    end else if (win_end) begin
      prev    <= result;
      adc_o   <= (MSBI_G + 1)'(({1'b0, result} + {1'b0, prev}) >> 1);
      valid_o <= 1'b1;
    end else begin
      valid_o <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      adc_o   <= '0;
      valid_o <= 1'b0;
    end else if (win_end) begin
      adc_o   <= result;
      valid_o <= 1'b1;
    end else begin
      valid_o <= 1'b0;
    end
  end
`endif

endmodule
